// File: rtl/deskew_axi_pkg.sv
// Shared types for the deskew AXI4-Lite front end: response codes, FSM states
// and the default top decoded register address.
package deskew_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_EXEC    = 2'd1,
    W_RESP    = 2'd2
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACCESS = 2'd1,
    R_WAIT   = 2'd2,
    R_RESP   = 2'd3
  } rstate_t;

  localparam logic [7:0] REG_MAX_ADDR_DEFAULT = 8'h1C;

endpackage

// File: rtl/deskew_axi_addr_chk.sv
// Combinational legality check for a register access: range first (DECERR),
// then word alignment and full byte strobes (SLVERR).
module deskew_axi_addr_chk
  import deskew_axi_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] REG_MAX_ADDR = ADDR_W'(REG_MAX_ADDR_DEFAULT)
) (
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W/8-1:0] strb_i,
  output resp_t               resp_o
);

  always_comb begin
    resp_o = RESP_OKAY;
    if (addr_i > REG_MAX_ADDR) begin
      resp_o = RESP_DECERR;
    end else if ((addr_i[1:0] != 2'b00) || (strb_i != '1)) begin
      resp_o = RESP_SLVERR;
    end
  end

endmodule

// File: rtl/deskew_axi2reg.sv
// AXI4-Lite slave that turns write/read transactions into single-cycle register
// strobes for the deskew register block; read and write paths run independently.
module deskew_axi2reg
  import deskew_axi_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] REG_MAX_ADDR = ADDR_W'(REG_MAX_ADDR_DEFAULT),
  parameter int unsigned       READ_LAT     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic                write_reg,
  output logic [ADDR_W-1:0]   reg_waddr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic                read_reg,
  output logic [ADDR_W-1:0]   reg_raddr,
  input  logic [DATA_W-1:0]   reg_rdata
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  // Write path state
  wstate_t             wstate_q, wstate_d;
  logic                aw_got_q, aw_got_d;
  logic                w_got_q, w_got_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  resp_t               bresp_q, bresp_d;
  resp_t               wchk;

  // Read path state
  rstate_t             rstate_q, rstate_d;
  logic                arready_q, arready_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  resp_t               rresp_q, rresp_d;
  resp_t               rchk;

  deskew_axi_addr_chk #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .REG_MAX_ADDR (REG_MAX_ADDR)
  ) u_wchk (
    .addr_i (awaddr_q),
    .strb_i (wstrb_q),
    .resp_o (wchk)
  );

  // Reads carry no strobes, so the strobe check is fed all-ones.
  deskew_axi_addr_chk #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .REG_MAX_ADDR (REG_MAX_ADDR)
  ) u_rchk (
    .addr_i (araddr_q),
    .strb_i ('1),
    .resp_o (rchk)
  );

  always_comb begin
    wstate_d = wstate_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    case (wstate_q)
      W_COLLECT: begin
        if (s_axi_awvalid && awready_q) begin
          aw_got_d = 1'b1;
          awaddr_d = s_axi_awaddr;
        end
        if (s_axi_wvalid && wready_q) begin
          w_got_d = 1'b1;
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
        end
        if (aw_got_d && w_got_d) wstate_d = W_EXEC;
      end
      W_EXEC: begin
        bvalid_d = 1'b1;
        bresp_d  = wchk;
        wstate_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          wstate_d = W_COLLECT;
        end
      end
      default: wstate_d = W_COLLECT;
    endcase
    // Readies are registered so they stay low throughout reset.
    awready_d = (wstate_d == W_COLLECT) && !aw_got_d;
    wready_d  = (wstate_d == W_COLLECT) && !w_got_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    rcnt_d   = rcnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          araddr_d = s_axi_araddr;
          rstate_d = R_ACCESS;
        end
      end
      R_ACCESS: begin
        if (rchk == RESP_OKAY) begin
          rcnt_d   = '0;
          rstate_d = R_WAIT;
        end else begin
          rvalid_d = 1'b1;
          rresp_d  = rchk;
          rdata_d  = '0;
          rstate_d = R_RESP;
        end
      end
      R_WAIT: begin
        if (rcnt_q == CNT_W'(READ_LAT - 1)) begin
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          rdata_d  = reg_rdata;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_COLLECT;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      araddr_q  <= '0;
      rcnt_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      araddr_q  <= araddr_d;
      rcnt_q    <= rcnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  // Strobes are decoded from the one-cycle EXEC/ACCESS states, so each fires once.
  assign write_reg = (wstate_q == W_EXEC) && (wchk == RESP_OKAY);
  assign reg_waddr = awaddr_q;
  assign reg_wdata = wdata_q;
  assign read_reg  = (rstate_q == R_ACCESS) && (rchk == RESP_OKAY);
  assign reg_raddr = araddr_q;

endmodule

// File: tb/tb_deskew_axi2reg.sv
// Directed testbench for deskew_axi2reg with a one-cycle-latency register model.
module tb_deskew_axi2reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        write_reg;
  logic [7:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        read_reg;
  logic [7:0]  reg_raddr;
  logic [31:0] reg_rdata;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  deskew_axi2reg #(
    .ADDR_W       (8),
    .DATA_W       (32),
    .REG_MAX_ADDR (8'h1C),
    .READ_LAT     (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .write_reg     (write_reg),
    .reg_waddr     (reg_waddr),
    .reg_wdata     (reg_wdata),
    .read_reg      (read_reg),
    .reg_raddr     (reg_raddr),
    .reg_rdata     (reg_rdata)
  );

  function automatic logic [31:0] model(input logic [2:0] idx);
    if (idx == 3'd3) return 32'hA5A5_0007;
    return {16'hC0DE, 13'd0, idx};
  endfunction

  // Register file model: data valid only in the cycle after read_reg.
  always @(posedge clk) begin
    reg_rdata <= (read_reg === 1'b1) ? model(reg_raddr[4:2]) : 32'hDEAD_BEEF;
    if (write_reg === 1'b1) wr_cnt <= wr_cnt + 1;
    if (read_reg === 1'b1)  rd_cnt <= rd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic tmo);
    logic aw_hs, w_hs, done;
    done = 1'b0;
    resp = 2'bxx;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      if (s_axi_bvalid) begin
        resp = s_axi_bresp;
        done = 1'b1;
      end
      tick();
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid = 1'b0;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    tmo = !done;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic tmo);
    logic ar_hs, done;
    done = 1'b0;
    d = 'x; resp = 2'bxx;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      ar_hs = s_axi_arvalid && s_axi_arready;
      if (s_axi_rvalid) begin
        d = s_axi_rdata;
        resp = s_axi_rresp;
        done = 1'b1;
      end
      tick();
      if (ar_hs) s_axi_arvalid = 1'b0;
    end
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    tmo = !done;
  endtask

  task automatic test_reset();
    logic [127:0] obs;
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) tick();
    obs = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
           write_reg, read_reg, s_axi_bresp, s_axi_rresp, s_axi_rdata, reg_waddr,
           reg_wdata, reg_raddr};
    checks++;
    if (obs !== 128'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", obs);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset got %b expected 111",
               {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_write_basic();
    int wr0 = wr_cnt;
    s_axi_awaddr = 8'h00; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h3; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++;
    if ({write_reg, reg_waddr, reg_wdata, s_axi_bvalid} !== {1'b1, 8'h00, 32'h3, 1'b0}) begin
      errors++;
      $display("FAIL wr_basic_strobe got wr=%b a=%h d=%h bv=%b expected wr=1 a=00 d=3 bv=0",
               write_reg, reg_waddr, reg_wdata, s_axi_bvalid);
    end
    tick();
    checks++;
    if ({write_reg, s_axi_bvalid, s_axi_bresp} !== {1'b0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL wr_basic_resp got wr=%b bv=%b br=%b expected wr=0 bv=1 br=00",
               write_reg, s_axi_bvalid, s_axi_bresp);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0 || wr_cnt - wr0 != 1) begin
      errors++;
      $display("FAIL wr_basic_done got bv=%b pulses=%0d expected bv=0 pulses=1",
               s_axi_bvalid, wr_cnt - wr0);
    end
  endtask

  task automatic test_w_before_aw();
    int wr0 = wr_cnt;
    s_axi_wdata = 32'hFF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    tick();
    s_axi_wvalid = 1'b0;
    checks++;
    if ({s_axi_wready, s_axi_awready, write_reg} !== 3'b010) begin
      errors++;
      $display("FAIL w_first_ready got wready=%b awready=%b wr=%b expected 0 1 0",
               s_axi_wready, s_axi_awready, write_reg);
    end
    tick();
    tick();
    s_axi_awaddr = 8'h10; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    checks++;
    if ({write_reg, reg_waddr, reg_wdata} !== {1'b1, 8'h10, 32'hFF}) begin
      errors++;
      $display("FAIL w_first_strobe got wr=%b a=%h d=%h expected wr=1 a=10 d=000000ff",
               write_reg, reg_waddr, reg_wdata);
    end
    tick();
    s_axi_bready = 1'b1;
    checks++;
    if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
      errors++;
      $display("FAIL w_first_resp got bv=%b br=%b expected bv=1 br=00", s_axi_bvalid, s_axi_bresp);
    end
    tick();
    s_axi_bready = 1'b0;
    checks++;
    if (wr_cnt - wr0 != 1) begin
      errors++;
      $display("FAIL w_first_pulses got %0d expected 1", wr_cnt - wr0);
    end
  endtask

  task automatic test_read_latency();
    int rd0 = rd_cnt;
    s_axi_araddr = 8'h0C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    checks++;
    if ({read_reg, reg_raddr, s_axi_rvalid} !== {1'b1, 8'h0C, 1'b0}) begin
      errors++;
      $display("FAIL rd_lat_strobe got rr=%b a=%h rv=%b expected rr=1 a=0c rv=0",
               read_reg, reg_raddr, s_axi_rvalid);
    end
    tick();
    checks++;
    if ({read_reg, s_axi_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_lat_wait got rr=%b rv=%b expected 0 0", read_reg, s_axi_rvalid);
    end
    tick();
    checks++;
    if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, 32'hA5A5_0007, 2'b00}) begin
      errors++;
      $display("FAIL rd_lat_resp got rv=%b d=%h r=%b expected rv=1 d=a5a50007 r=00",
               s_axi_rvalid, s_axi_rdata, s_axi_rresp);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, 32'hA5A5_0007, 2'b00}) begin
        errors++;
        $display("FAIL rd_stable[%0d] got rv=%b d=%h r=%b expected rv=1 d=a5a50007 r=00",
                 i, s_axi_rvalid, s_axi_rdata, s_axi_rresp);
      end
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    checks++;
    if (s_axi_rvalid !== 1'b0 || rd_cnt - rd0 != 1) begin
      errors++;
      $display("FAIL rd_lat_done got rv=%b pulses=%0d expected rv=0 pulses=1",
               s_axi_rvalid, rd_cnt - rd0);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [31:0] d;
    logic tmo;
    int wr0 = wr_cnt;
    int rd0 = rd_cnt;
    axi_write(8'h05, 32'h1234, 4'hF, resp, tmo);
    checks++;
    if (tmo || resp !== 2'b10 || wr_cnt != wr0) begin
      errors++;
      $display("FAIL wr_unaligned got tmo=%b br=%b pulses=%0d expected tmo=0 br=10 pulses=0",
               tmo, resp, wr_cnt - wr0);
    end
    axi_write(8'h20, 32'h1234, 4'hF, resp, tmo);
    checks++;
    if (tmo || resp !== 2'b11 || wr_cnt != wr0) begin
      errors++;
      $display("FAIL wr_range got tmo=%b br=%b pulses=%0d expected tmo=0 br=11 pulses=0",
               tmo, resp, wr_cnt - wr0);
    end
    axi_write(8'h1C, 32'h5, 4'hF, resp, tmo);
    checks++;
    if (tmo || resp !== 2'b00 || wr_cnt - wr0 != 1) begin
      errors++;
      $display("FAIL wr_top_addr got tmo=%b br=%b pulses=%0d expected tmo=0 br=00 pulses=1",
               tmo, resp, wr_cnt - wr0);
    end
    axi_read(8'h40, d, resp, tmo);
    checks++;
    if (tmo || resp !== 2'b11 || d !== 32'h0 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL rd_range got tmo=%b r=%b d=%h pulses=%0d expected tmo=0 r=11 d=0 pulses=0",
               tmo, resp, d, rd_cnt - rd0);
    end
    axi_read(8'h06, d, resp, tmo);
    checks++;
    if (tmo || resp !== 2'b10 || d !== 32'h0 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL rd_unaligned got tmo=%b r=%b d=%h pulses=%0d expected tmo=0 r=10 d=0 pulses=0",
               tmo, resp, d, rd_cnt - rd0);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] bresp, rresp;
    logic [31:0] d;
    logic wtmo, rtmo;
    int wr0 = wr_cnt;
    int rd0 = rd_cnt;
    fork
      axi_write(8'h04, 32'hCAFE, 4'h3, bresp, wtmo);
      axi_read(8'h04, d, rresp, rtmo);
    join
    checks++;
    if (wtmo || bresp !== 2'b10 || wr_cnt != wr0) begin
      errors++;
      $display("FAIL conc_write got tmo=%b br=%b pulses=%0d expected tmo=0 br=10 pulses=0",
               wtmo, bresp, wr_cnt - wr0);
    end
    checks++;
    if (rtmo || rresp !== 2'b00 || d !== 32'hC0DE_0001 || rd_cnt - rd0 != 1) begin
      errors++;
      $display("FAIL conc_read got tmo=%b r=%b d=%h pulses=%0d expected tmo=0 r=00 d=c0de0001 pulses=1",
               rtmo, rresp, d, rd_cnt - rd0);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    logic [31:0] d, exp_d;
    logic tmo;
    logic [7:0] a;
    int rd0 = rd_cnt;
    for (int i = 0; i < 8; i++) begin
      a = 8'(i * 4);
      exp_d = model(3'(i));
      axi_read(a, d, resp, tmo);
      checks++;
      if (tmo || resp !== 2'b00 || d !== exp_d) begin
        errors++;
        $display("FAIL b2b_read[%h] got tmo=%b r=%b d=%h expected tmo=0 r=00 d=%h",
                 a, tmo, resp, d, exp_d);
      end
    end
    checks++;
    if (rd_cnt - rd0 != 8) begin
      errors++;
      $display("FAIL b2b_pulses got %0d expected 8", rd_cnt - rd0);
    end
    // Abort a read while it waits on register data.
    s_axi_araddr = 8'h08; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_axi_rvalid, s_axi_arready, read_reg} !== 3'b000) begin
      errors++;
      $display("FAIL midread_reset got rv=%b arready=%b rr=%b expected 0 0 0",
               s_axi_rvalid, s_axi_arready, read_reg);
    end
    tick();
    rst_n = 1'b1;
    rd0 = rd_cnt;
    repeat (4) tick();
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL post_reset_idle got rv=%b arready=%b pulses=%0d expected 0 1 0",
               s_axi_rvalid, s_axi_arready, rd_cnt - rd0);
    end
    axi_read(8'h14, d, resp, tmo);
    checks++;
    if (tmo || resp !== 2'b00 || d !== 32'hC0DE_0005) begin
      errors++;
      $display("FAIL post_reset_read got tmo=%b r=%b d=%h expected tmo=0 r=00 d=c0de0005",
               tmo, resp, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_w_before_aw();
    test_read_latency();
    test_errors();
    test_concurrent();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deskew_axi2reg.md
Name: deskew_axi2reg

Overview:
AXI4-Lite slave front end for the deskew register block. Converts AXI4-Lite write/read transactions into the single-cycle register strobes (write_reg/reg_waddr/reg_wdata, read_reg/reg_raddr) and returns reg_rdata as the AXI read response. It sits directly upstream of deskew_reg_block, between the system interconnect and the register file. Read and write paths are independent and may be active in the same cycle.

Parameters:
ADDR_W, 8, AXI and register address width (byte address)
DATA_W, 32, data width (only 32 supported)
REG_MAX_ADDR, 8'h1C, highest decoded byte address; above it -> DECERR, no register access
READ_LAT, 1, cycles between the read_reg pulse cycle and the cycle in which reg_rdata is sampled

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  DATA_W  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out/in  1  R handshake
write_reg  out  1  one-cycle register write strobe
reg_waddr  out  ADDR_W  register write address
reg_wdata  out  DATA_W  register write data
read_reg  out  1  one-cycle register read strobe
reg_raddr  out  ADDR_W  register read address
reg_rdata  in  DATA_W  register read data

Behaviour:
- Reset (rst_n low, async): all *ready, bvalid, rvalid, write_reg, read_reg = 0; bresp, rresp, rdata, reg_waddr, reg_wdata, reg_raddr = 0; both FSMs to idle. Reset mid-transaction aborts it; no strobe is issued after release.
- Write FSM: W_COLLECT -> W_EXEC -> W_RESP -> W_COLLECT.
  - W_COLLECT: awready = !aw_got, wready = !w_got (both 1 from first cycle after reset). AW and W captured independently, in either order or together; each is held once captured.
  - Both captured -> W_EXEC (1 cycle): if awaddr[1:0]==0, wstrb==all-ones and awaddr<=REG_MAX_ADDR, write_reg=1 with reg_waddr/reg_wdata = captured values; otherwise no strobe.
  - W_RESP: bvalid=1 until bready; bresp = OKAY 2'b00, SLVERR 2'b10 (unaligned or partial wstrb), DECERR 2'b11 (out of range; checked first). Clear flags on B handshake.
  - Minimum latency: AW+W handshake in cycle 0 -> write_reg in cycle 1 -> bvalid in cycle 2.
- Read FSM: R_IDLE -> R_ACCESS -> R_WAIT -> R_RESP -> R_IDLE.
  - R_IDLE: arready=1; on handshake latch araddr.
  - R_ACCESS (1 cycle): if legal, read_reg=1, reg_raddr=latched address; illegal (unaligned -> SLVERR, out of range -> DECERR) skips to R_RESP with rdata=0.
  - R_WAIT: READ_LAT cycles; reg_rdata is sampled into s_axi_rdata at the clock edge ending the last wait cycle.
  - R_RESP: rvalid=1, rdata/rresp stable until rready. READ_LAT=1: AR handshake cycle 0, read_reg cycle 1, rvalid cycle 3.
- One outstanding transaction per direction; no new AR/AW/W is accepted until the response handshake completes.
- Simultaneous read and write to the same address: both strobes may fire in the same cycle; ordering is the register block's responsibility.
- bvalid/rvalid never deassert without the matching ready; data/resp stable while valid.
- read_reg and write_reg are each high for exactly one cycle per legal transaction.

Decomposition:
- Package deskew_axi_pkg: resp_t enum (OKAY, EXOKAY, SLVERR, DECERR), write/read FSM state enums, REG_MAX_ADDR default.
- One sub-module, deskew_axi_addr_chk: combinational alignment/range/strobe check returning resp_t. It is used by both the write and read FSMs.

Test Plan:
- AW and W together, addr 8'h00, data 32'h3, wstrb F -> write_reg pulse in cycle 1 with waddr 00/wdata 3; bvalid in cycle 2, bresp 00.
- W 3 cycles before AW (addr 8'h10, data 32'hFF) -> wready drops after W capture; single write_reg after AW; bresp 00.
- Read 8'h0C with reg_rdata model returning 32'hA5A5_0007 one cycle after read_reg -> read_reg in cycle 1, rvalid in cycle 3, rdata A5A5_0007, rresp 00; rready held low 5 cycles -> rdata stable.
- Write addr 8'h05 -> no write_reg, bresp 10; read 8'h40 -> no read_reg, rdata 0, rresp 11.
- Write wstrb 4'h3 to 8'h04 -> no strobe, bresp 10; concurrent read of 8'h04 in the same cycle -> read proceeds, rresp 00.
- Back-to-back reads 8'h00..8'h1C, rready=1 -> 8 read_reg pulses, each rdata matches the model; rst_n pulsed low mid-read -> rvalid=0, FSM idle, next read completes normally.
